axi_bw_arbiter_rr: RTL and testbench

//  Write-response (B) arbiter for the axi_node backward path. Collects B beats

---
 rtl/axi_bw_arbiter_rr.sv | 108 ++++++++++
 tb/tb_axi_bw_arbiter_rr.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_bw_arbiter_rr.sv
// Purpose: round-robin arbiter sharing one target-port B channel between N_INIT_PORT sources.
// Latency: one cycle from source handshake to bvalid_o; one beat per cycle under continuous bready_i.
// Backpressure: a full slot with bready_i low holds its beat and drops all bready_o to zero.
module axi_bw_arbiter_rr #(
    parameter int N_INIT_PORT = 4,
    parameter int AXI_ID      = 6,
    parameter int AXI_USER    = 6
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [N_INIT_PORT*AXI_ID-1:0]   bid_i,
    input  logic [N_INIT_PORT*2-1:0]        bresp_i,
    input  logic [N_INIT_PORT*AXI_USER-1:0] buser_i,
    input  logic [N_INIT_PORT-1:0]          bvalid_i,
    output logic [N_INIT_PORT-1:0]          bready_o,
    output logic [AXI_ID-1:0]               bid_o,
    output logic [1:0]                      bresp_o,
    output logic [AXI_USER-1:0]             buser_o,
    output logic                            bvalid_o,
    input  logic                            bready_i
);

    localparam int PTR_W = (N_INIT_PORT > 1) ? $clog2(N_INIT_PORT) : 1;

    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic                full_q, full_d;
    logic [AXI_ID-1:0]   id_q, id_d;
    logic [1:0]          resp_q, resp_d;
    logic [AXI_USER-1:0] user_q, user_d;

    logic [PTR_W-1:0]    grant_idx;
    logic                grant_vld;
    logic                can_load;
    logic                src_hs;

    // The slot can take a new beat when it is empty or is being drained this cycle.
    assign can_load = !full_q || bready_i;

    // Scan requests starting at rr_ptr, wrapping at N_INIT_PORT (which need not be a power of two).
    always_comb begin
        int cand;
        cand      = 0;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < N_INIT_PORT; i++) begin
            cand = int'(rr_ptr_q) + i;
            if (cand >= N_INIT_PORT) begin
                cand = cand - N_INIT_PORT;
            end
            if (!grant_vld && bvalid_i[cand]) begin
                grant_vld = 1'b1;
                grant_idx = PTR_W'(cand);
            end
        end
    end

    // One-hot ready to the granted source; nothing is accepted while reset is asserted.
    always_comb begin
        bready_o = '0;
        if (!rst_i && can_load && grant_vld) begin
            bready_o[grant_idx] = 1'b1;
        end
    end

    // Ready is only raised toward a requesting source, so any ready bit is a handshake.
    assign src_hs = |bready_o;

    // Next-state: load the granted beat and advance the pointer past the winner, or drain.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        full_d   = full_q;
        id_d     = id_q;
        resp_d   = resp_q;
        user_d   = user_q;
        if (src_hs) begin
            full_d   = 1'b1;
            id_d     = bid_i[int'(grant_idx)*AXI_ID +: AXI_ID];
            resp_d   = bresp_i[int'(grant_idx)*2 +: 2];
            user_d   = buser_i[int'(grant_idx)*AXI_USER +: AXI_USER];
            rr_ptr_d = (grant_idx == PTR_W'(N_INIT_PORT - 1)) ? '0 : grant_idx + 1'b1;
        end else if (bready_i) begin
            full_d = 1'b0;
        end
    end

    // State register; reset drops any held beat without replay.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q <= '0;
            full_q   <= 1'b0;
            id_q     <= '0;
            resp_q   <= '0;
            user_q   <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            full_q   <= full_d;
            id_q     <= id_d;
            resp_q   <= resp_d;
            user_q   <= user_d;
        end
    end

    assign bvalid_o = full_q;
    assign bid_o    = id_q;
    assign bresp_o  = resp_q;
    assign buser_o  = user_q;

endmodule

// File: tb/tb_axi_bw_arbiter_rr.sv
// Bench for axi_bw_arbiter_rr: a 4-source and a 3-source instance driven in lockstep.
// Expected beats are queued at each predicted source handshake and popped on output drain.
// Grant order is predicted by a small round-robin reference model.
module tb_axi_bw_arbiter_rr;

    typedef struct packed {
        logic [5:0] id;
        logic [1:0] resp;
        logic [5:0] user;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] bid_i;
    logic [7:0]  bresp_i;
    logic [23:0] buser_i;
    logic [3:0]  bvalid_i;
    logic [2:0]  bvalid3_i;
    logic        bready_i;

    logic [3:0]  bready4;
    logic [5:0]  bid4;
    logic [1:0]  bresp4;
    logic [5:0]  buser4;
    logic        bvalid4;

    logic [2:0]  bready3;
    logic [5:0]  bid3;
    logic [1:0]  bresp3;
    logic [5:0]  buser3;
    logic        bvalid3;

    int    n_cmp = 0;
    int    n_err = 0;
    int    m_ptr4, m_ptr3;
    bit    m_full4, m_full3;
    beat_t q4[$];
    beat_t q3[$];
    logic [3:0] last_rdy4;
    logic [2:0] last_rdy3;

    always #5 clk = ~clk;

    axi_bw_arbiter_rr #(.N_INIT_PORT(4), .AXI_ID(6), .AXI_USER(6)) dut4 (
        .clk_i    (clk),
        .rst_i    (rst),
        .bid_i    (bid_i),
        .bresp_i  (bresp_i),
        .buser_i  (buser_i),
        .bvalid_i (bvalid_i),
        .bready_o (bready4),
        .bid_o    (bid4),
        .bresp_o  (bresp4),
        .buser_o  (buser4),
        .bvalid_o (bvalid4),
        .bready_i (bready_i)
    );

    axi_bw_arbiter_rr #(.N_INIT_PORT(3), .AXI_ID(6), .AXI_USER(6)) dut3 (
        .clk_i    (clk),
        .rst_i    (rst),
        .bid_i    (bid_i[17:0]),
        .bresp_i  (bresp_i[5:0]),
        .buser_i  (buser_i[17:0]),
        .bvalid_i (bvalid3_i),
        .bready_o (bready3),
        .bid_o    (bid3),
        .bresp_o  (bresp3),
        .buser_o  (buser3),
        .bvalid_o (bvalid3),
        .bready_i (bready_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int mgrant(input logic [3:0] v, input int n, input int ptr);
        for (int i = 0; i < n; i++) begin
            int j = (ptr + i) % n;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    function automatic beat_t src_beat(input int k);
        beat_t b;
        b.id   = bid_i[k*6 +: 6];
        b.resp = bresp_i[k*2 +: 2];
        b.user = buser_i[k*6 +: 6];
        return b;
    endfunction

    task automatic rand_data();
        bid_i   = 24'($urandom);
        bresp_i = 8'($urandom);
        buser_i = 24'($urandom);
    endtask

    // Compares one instance against the model and returns the model's next state.
    task automatic check_port(input string nm, input int n, input logic [3:0] v,
                              input logic [3:0] rdy_o, input logic vld_o, input beat_t obs,
                              input int ptr_in, input bit full_in,
                              input bit have_front, input beat_t front,
                              output int ptr_out, output bit full_out,
                              output bit push, output bit pop, output beat_t pushed);
        int         g;
        bit         can;
        logic [3:0] exp_rdy;
        g       = mgrant(v, n, ptr_in);
        can     = !full_in || bready_i;
        exp_rdy = (can && g >= 0) ? 4'(1 << g) : 4'b0000;
        chk({nm, ".bready_o"}, 32'(rdy_o), 32'(exp_rdy));
        chk({nm, ".bvalid_o"}, 32'(vld_o), 32'(full_in));
        if (full_in && have_front) begin
            chk({nm, ".beat"}, 32'(obs), 32'(front));
        end
        pop      = full_in && bready_i;
        push     = (exp_rdy != 4'b0000);
        pushed   = push ? src_beat(g) : '0;
        full_out = push ? 1'b1 : (bready_i ? 1'b0 : full_in);
        ptr_out  = push ? ((g == n - 1) ? 0 : g + 1) : ptr_in;
    endtask

    // Drive one cycle of inputs, check both instances mid-cycle, then advance to the next negedge.
    task automatic step(input logic [3:0] v4, input logic [2:0] v3, input logic rdy);
        int    np;
        bit    nf, pu, po;
        beat_t pb;
        bvalid_i  = v4;
        bvalid3_i = v3;
        bready_i  = rdy;
        #1;
        last_rdy4 = bready4;
        last_rdy3 = bready3;
        check_port("n4", 4, v4, bready4, bvalid4, {bid4, bresp4, buser4}, m_ptr4, m_full4,
                   q4.size() > 0, (q4.size() > 0) ? q4[0] : beat_t'(0), np, nf, pu, po, pb);
        if (po && q4.size() > 0) void'(q4.pop_front());
        if (pu) q4.push_back(pb);
        m_ptr4  = np;
        m_full4 = nf;
        check_port("n3", 3, {1'b0, v3}, {1'b0, bready3}, bvalid3, {bid3, bresp3, buser3},
                   m_ptr3, m_full3, q3.size() > 0, (q3.size() > 0) ? q3[0] : beat_t'(0),
                   np, nf, pu, po, pb);
        if (po && q3.size() > 0) void'(q3.pop_front());
        if (pu) q3.push_back(pb);
        m_ptr3  = np;
        m_full3 = nf;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) begin
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        chk("rst.bvalid4", 32'(bvalid4), 32'd0);
        chk("rst.bready4", 32'(bready4), 32'd0);
        chk("rst.fields4", 32'({bid4, bresp4, buser4}), 32'd0);
        chk("rst.bvalid3", 32'(bvalid3), 32'd0);
        chk("rst.bready3", 32'(bready3), 32'd0);
        rst     = 1'b0;
        m_ptr4  = 0;
        m_ptr3  = 0;
        m_full4 = 1'b0;
        m_full3 = 1'b0;
        q4.delete();
        q3.delete();
    endtask

    initial begin
        int order[6] = '{0, 1, 2, 3, 0, 1};
        rst       = 1'b1;
        bvalid_i  = 4'hF;
        bvalid3_i = 3'b111;
        bready_i  = 1'b1;
        rand_data();

        // Reset held two cycles with every source requesting.
        do_reset(2);

        // Single beat from source 2.
        rand_data();
        bid_i[12 +: 6]  = 6'h15;
        bresp_i[4 +: 2] = 2'b10;
        step(4'b0100, 3'b000, 1'b1);
        chk("single.bready4", 32'(last_rdy4), 32'h4);
        #1;
        chk("single.bvalid4", 32'(bvalid4), 32'd1);
        chk("single.bid4", 32'(bid4), 32'h15);
        chk("single.bresp4", 32'(bresp4), 32'h2);
        step(4'b0000, 3'b000, 1'b1);

        // Fairness with all sources requesting and no backpressure.
        do_reset(1);
        for (int i = 0; i < 6; i++) begin
            rand_data();
            step(4'hF, 3'b000, 1'b1);
            chk("fair.grant", 32'(last_rdy4), 32'(1 << order[i]));
        end
        step(4'b0000, 3'b000, 1'b1);

        // Backpressure: load, stall five cycles, then drain with a same-cycle regrant.
        rand_data();
        step(4'hF, 3'b000, 1'b0);
        chk("bp.load", 32'(last_rdy4), 32'h4);
        for (int i = 0; i < 5; i++) begin
            rand_data();
            step(4'hF, 3'b000, 1'b0);
        end
        rand_data();
        step(4'hF, 3'b000, 1'b1);
        chk("bp.regrant", 32'(last_rdy4), 32'h8);
        #1;
        chk("bp.backtoback", 32'(bvalid4), 32'd1);
        step(4'b0000, 3'b000, 1'b1);

        // Wrap on the three-source instance.
        do_reset(1);
        rand_data();
        step(4'b0000, 3'b100, 1'b1);
        chk("wrap.src2", 32'(last_rdy3), 32'h4);
        rand_data();
        step(4'b0000, 3'b001, 1'b1);
        chk("wrap.src0", 32'(last_rdy3), 32'h1);
        rand_data();
        step(4'b0000, 3'b011, 1'b1);
        chk("wrap.src1_first", 32'(last_rdy3), 32'h2);
        rand_data();
        step(4'b0000, 3'b011, 1'b1);
        chk("wrap.src0_after", 32'(last_rdy3), 32'h1);
        step(4'b0000, 3'b000, 1'b1);

        // Reset while stalled, then verify the pointer restarted at zero.
        rand_data();
        step(4'b0010, 3'b000, 1'b0);
        step(4'b0000, 3'b000, 1'b0);
        bvalid_i = 4'b0000;
        do_reset(1);
        rand_data();
        step(4'b1010, 3'b000, 1'b1);
        chk("rstmid.ptr0", 32'(last_rdy4), 32'h2);
        rand_data();
        step(4'b1000, 3'b000, 1'b1);
        chk("rstmid.src3", 32'(last_rdy4), 32'h8);
        step(4'b0000, 3'b000, 1'b1);

        // Random traffic with random backpressure.
        for (int i = 0; i < 300; i++) begin
            rand_data();
            step(4'($urandom), 3'($urandom), ($urandom_range(0, 3) != 0));
        end
        step(4'b0000, 3'b000, 1'b1);
        step(4'b0000, 3'b000, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
